fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream drain stage for `synchronous_FIFO`.
- Pops bytes from the FIFO read port whenever the FIFO is non-empty and sending is enabled.
- Serializes each byte onto a UART-style line: 1 start bit, WIDTH data bits LSB first, STOP_BITS stop bits.
- Sits between the FIFO and the chip-level serial pin and is the sole driver of the FIFO `r_en`.

Parameters:
- WIDTH, 8: data bits per frame; must equal the FIFO WIDTH.
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 2.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enables fetching new bytes; does not abort a frame already in progress.
- fifo_empty  input  1  connects to FIFO `empty`.
- fifo_rdata  input  WIDTH  connects to FIFO `data_out`; valid the cycle after `r_en` is sampled high.
- fifo_rd_en  output  1  connects to FIFO `r_en`; single-cycle pop strobe.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  high while a frame is being fetched or transmitted.
- tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (asynchronous assert, takes effect immediately):
  - state = IDLE, tx = 1, busy = 0, fifo_rd_en = 0, tx_done = 0.
  - Bit counter, cycle counter and shift register cleared.
- FSM states: IDLE, WAIT, START, DATA, STOP.
- IDLE:
  - fifo_rd_en = en && !fifo_empty (combinational, this state only).
  - Moves to WAIT when fifo_rd_en = 1.
  - tx = 1, busy = 0.
- WAIT (exactly 1 cycle):
  - Shift register loads fifo_rdata at the end of this cycle.
  - tx = 1, busy = 1.
  - Moves to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift_reg[0], held for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit; WIDTH bits in total, then STOP.
- STOP:
  - tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done = 1 on the final cycle, then IDLE.
- Counters:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - Bit counter is $clog2(WIDTH+1) bits.
  - No other arithmetic in the block.
- Frame timing, with the fifo_rd_en cycle as cycle t:
  - START first cycle = t+2.
  - Frame length = (1 + WIDTH + STOP_BITS)*CLKS_PER_BIT cycles.
  - Next earliest fifo_rd_en = t + 2 + frame length.
  - Result: a minimum 2-cycle idle gap (IDLE + WAIT) between frames, tx = 1 throughout the gap.
- fifo_rd_en is never asserted outside IDLE and never while fifo_empty = 1, so the block cannot underflow the FIFO.
- en deasserted mid-frame: the frame completes normally; the block then stays in IDLE.
- fifo_empty changing mid-frame: ignored.
- tx is registered (glitch-free). fifo_rd_en is the only combinational output.
- Reset mid-frame:
  - The frame is aborted and tx returns to 1 immediately.
  - The byte already popped is lost; this is accepted, and the FIFO is reset together with this block.
- en = 1 and FIFO non-empty on the first cycle after reset release: fifo_rd_en asserts that same cycle.

Test Plan (CLKS_PER_BIT = 4, STOP_BITS = 1, WIDTH = 8, FIFO DEPTH = 8):
1. Write 0xA5 into the FIFO, en = 1.
   - Exactly 1 fifo_rd_en pulse.
   - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total).
   - busy high for 41 cycles; tx_done single pulse on the last stop cycle.
2. Write 0x01, 0x80, 0xFF back-to-back.
   - fifo_rd_en pulses exactly 3 times, 42 cycles apart.
   - Decoded bytes 0x01, 0x80, 0xFF, in that order.
   - FIFO ends with empty = 1.
3. FIFO empty, en = 1 for 100 cycles: fifo_rd_en never asserts, tx = 1, busy = 0.
4. Load 2 bytes, drop en in the middle of the first frame.
   - First frame completes and tx_done pulses once.
   - No second pop while en = 0.
   - Raising en starts the second frame within 1 cycle.
5. Assert rst during DATA bit 3 of 0x3C.
   - tx = 1, busy = 0, tx_done = 0 in the same cycle.
   - After release with en = 1 and an empty FIFO: no activity.
6. Fill the FIFO to full (8 bytes 0x10..0x17).
   - All 8 bytes are transmitted in order.
   - full deasserts after the first pop.
   - Exactly 8 tx_done pulses.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a synchronous FIFO and the UART drain stage.
//   fifo_empty : FIFO empty flag
//   fifo_rdata : FIFO read data, valid the cycle after fifo_rd_en is sampled
//   fifo_rd_en : single-cycle pop strobe
// master = the drain stage (issues pops), slave = the FIFO side.
interface fifo_uart_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd_en
  );

endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO and serializes each byte onto a UART line:
// 1 start bit, WIDTH data bits LSB first, STOP_BITS stop bits.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   i_en      : allows fetching new bytes; a running frame always completes
//   bus       : FIFO read port (empty, rdata in; rd_en out, combinational)
//   o_tx      : serial line, idles high, registered
//   o_busy    : high while a frame is fetched or transmitted
//   o_tx_done : one-cycle pulse on the last cycle of the final stop bit
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  fifo_uart_tx_if.master        bus,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_tx_done, w_tx_done_nxt;
  logic             w_rd_en;
  logic             w_bit_end;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_tx_done <= w_tx_done_nxt;
    end
  end

  // Next-state, counters, and the output values for the coming cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_rd_en       = 1'b0;
    w_bit_end     = (r_cnt == CW'(CLKS_PER_BIT - 1));
    w_tx_nxt      = 1'b1;
    w_busy_nxt    = 1'b0;
    w_tx_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_rd_en = i_en && !bus.fifo_empty;
        if (w_rd_en) begin
          w_state_nxt = S_WAIT;
        end
      end
      // FIFO data becomes valid here, one cycle after the pop.
      S_WAIT: begin
        w_shift_nxt = bus.fifo_rdata;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BW'(WIDTH - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      // Bit counter is reused to count stop bits.
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit == BW'(STOP_BITS - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops line up with it.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_tx_done_nxt = (w_state_nxt == S_STOP) &&
                    (w_cnt_nxt == CW'(CLKS_PER_BIT - 1)) &&
                    (w_bit_nxt == BW'(STOP_BITS - 1));
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign o_tx           = r_tx;
  assign o_busy         = r_busy;
  assign o_tx_done      = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, frame-timeline reference model
// with a per-cycle compare, a line decoder, and directed scenarios.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int W  = 8;
  localparam int SB = 1;
  localparam int FL = (1 + W + SB) * C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic o_tx, o_busy, o_tx_done;

  logic f_empty = 1'b1;
  logic f_full = 1'b0;
  logic [7:0] f_rdata = 8'h00;
  logic [7:0] fq[$];

  int tests = 0;
  int fails = 0;

  // monitor-owned state
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int rd_times[$];
  logic [7:0] rxq[$];
  logic m_active = 1'b0;
  int m_t0 = 0;
  logic [7:0] m_byte = 8'h00;
  logic e_rd, e_tx, e_busy, e_done;
  int k, b;
  logic rx_busy = 1'b0;
  int rx_s = 0;
  logic [7:0] rx_byte = 8'h00;

  fifo_uart_tx_if #(.WIDTH(W)) bus ();
  assign bus.fifo_empty = f_empty;
  assign bus.fifo_rdata = f_rdata;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (en),
    .bus       (bus),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_tx_done (o_tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural FIFO, depth 8, registered read data.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      f_rdata <= 8'h00;
      f_empty <= 1'b1;
      f_full  <= 1'b0;
    end else begin
      if (bus.fifo_rd_en && fq.size() != 0) f_rdata <= fq.pop_front();
      if (wr_en && fq.size() < 8) fq.push_back(wr_data);
      f_empty <= (fq.size() == 0);
      f_full  <= (fq.size() == 8);
    end
  end

  // Reference model + per-cycle compare + event counters + line decoder.
  always @(negedge clk) begin
    cyc = cyc + 1;
    e_rd = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      rx_busy = 1'b0;
      e_rd = en && !f_empty;
    end else begin
      if (m_active && (cyc - m_t0) > FL + 1) m_active = 1'b0;
      if (!m_active && en && !f_empty) begin
        m_active = 1'b1;
        m_t0 = cyc;
        m_byte = fq[0];
      end
      if (m_active) begin
        k = cyc - m_t0;
        e_rd = (k == 0);
        e_busy = (k >= 1);
        e_done = (k == FL + 1);
        if (k >= 2) begin
          b = (k - 2) / C;
          if (b == 0) e_tx = 1'b0;
          else if (b <= W) e_tx = m_byte[b-1];
          else e_tx = 1'b1;
        end
      end
    end
    check("rd_en", bus.fifo_rd_en, e_rd);
    check("tx", o_tx, e_tx);
    check("busy", o_busy, e_busy);
    check("tx_done", o_tx_done, e_done);

    if (bus.fifo_rd_en) begin rd_cnt++; rd_times.push_back(cyc); end
    if (o_tx_done) done_cnt++;
    if (o_busy) busy_cyc++;

    // Decoder samples mid-bit relative to the start-bit edge.
    if (!rst) begin
      if (!rx_busy) begin
        if (o_tx == 1'b0) begin rx_busy = 1'b1; rx_s = cyc; end
      end else begin
        k = cyc - rx_s;
        for (int i = 0; i < W; i++)
          if (k == C / 2 + C * (i + 1)) rx_byte[i] = o_tx;
        if (k == C / 2 + C * (W + 1)) begin
          check("rx_stop", o_tx, 1'b1);
          rxq.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < bound) begin tick(); n++; end
    check(name, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_rd(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (rd_cnt < target && n < bound) begin tick(); n++; end
    check(name, 32'(rd_cnt >= target), 32'd1);
  endtask

  initial begin
    int r0, d0, b0, n0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int r0, d0, b0, n0;
    #1 rst = 1'b1;
    #1;
    check("reset_tx", o_tx, 1'b1);
    check("reset_busy", o_busy, 1'b0);
    check("reset_done", o_tx_done, 1'b0);
    check("reset_rd_en", bus.fifo_rd_en, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: single byte 0xA5
    en = 1'b1;
    r0 = rd_cnt; d0 = done_cnt; b0 = busy_cyc; n0 = rxq.size();
    write_byte(8'hA5);
    wait_done(d0 + 1, 100, "t1_wait_done");
    check("t1_pops", rd_cnt - r0, 1);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_busy_cycles", busy_cyc - b0, 41);
    check("t1_rx_count", rxq.size() - n0, 1);
    if (rxq.size() > n0) check("t1_byte", rxq[n0], 8'hA5);
    tick(); tick();

    // 2: three back-to-back bytes
    r0 = rd_cnt; d0 = done_cnt; n0 = rxq.size();
    write_byte(8'h01);
    write_byte(8'h80);
    write_byte(8'hFF);
    wait_done(d0 + 3, 200, "t2_wait_done");
    check("t2_pops", rd_cnt - r0, 3);
    if (rd_times.size() >= r0 + 3) begin
      check("t2_gap1", rd_times[r0+1] - rd_times[r0], 42);
      check("t2_gap2", rd_times[r0+2] - rd_times[r0+1], 42);
    end
    check("t2_rx_count", rxq.size() - n0, 3);
    if (rxq.size() >= n0 + 3) begin
      check("t2_byte0", rxq[n0], 8'h01);
      check("t2_byte1", rxq[n0+1], 8'h80);
      check("t2_byte2", rxq[n0+2], 8'hFF);
    end
    check("t2_fifo_empty", f_empty, 1'b1);

    // 3: empty FIFO with en high
    r0 = rd_cnt; b0 = busy_cyc;
    repeat (100) tick();
    check("t3_pops", rd_cnt - r0, 0);
    check("t3_busy_cycles", busy_cyc - b0, 0);
    check("t3_tx", o_tx, 1'b1);

    // 4: drop en mid-frame
    r0 = rd_cnt; d0 = done_cnt; n0 = rxq.size();
    write_byte(8'h5A);
    write_byte(8'hC3);
    wait_rd(r0 + 1, 20, "t4_wait_pop");
    repeat (20) tick();
    en = 1'b0;
    wait_done(d0 + 1, 60, "t4_wait_done1");
    check("t4_done_pulses", done_cnt - d0, 1);
    repeat (50) tick();
    check("t4_pops_while_off", rd_cnt - r0, 1);
    check("t4_fifo_holds_byte", f_empty, 1'b0);
    en = 1'b1;
    #1;
    check("t4_pop_on_enable", bus.fifo_rd_en, 1'b1);
    wait_done(d0 + 2, 60, "t4_wait_done2");
    check("t4_rx_count", rxq.size() - n0, 2);
    if (rxq.size() >= n0 + 2) begin
      check("t4_byte0", rxq[n0], 8'h5A);
      check("t4_byte1", rxq[n0+1], 8'hC3);
    end
    tick();

    // 5: reset during DATA bit 3 of 0x3C
    r0 = rd_cnt; n0 = rxq.size();
    write_byte(8'h3C);
    wait_rd(r0 + 1, 10, "t5_wait_pop");
    repeat (18) tick();
    check("t5_busy_before", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_tx", o_tx, 1'b1);
    check("t5_busy", o_busy, 1'b0);
    check("t5_done", o_tx_done, 1'b0);
    tick(); tick();
    rst = 1'b0;
    r0 = rd_cnt; b0 = busy_cyc; d0 = done_cnt;
    repeat (30) tick();
    check("t5_pops_after", rd_cnt - r0, 0);
    check("t5_busy_after", busy_cyc - b0, 0);
    check("t5_done_after", done_cnt - d0, 0);
    check("t5_rx_none", rxq.size() - n0, 0);

    // 6: fill FIFO, then drain all 8
    en = 1'b0;
    r0 = rd_cnt; d0 = done_cnt; n0 = rxq.size();
    for (int i = 0; i < 8; i++) write_byte(8'(8'h10 + i));
    check("t6_full", f_full, 1'b1);
    en = 1'b1;
    #1;
    check("t6_first_pop", bus.fifo_rd_en, 1'b1);
    tick();
    check("t6_full_after_pop", f_full, 1'b0);
    wait_done(d0 + 8, 8 * 42 + 40, "t6_wait_done");
    check("t6_done_pulses", done_cnt - d0, 8);
    check("t6_pops", rd_cnt - r0, 8);
    check("t6_rx_count", rxq.size() - n0, 8);
    for (int i = 0; i < 8; i++)
      if (rxq.size() > n0 + i) check("t6_byte", rxq[n0+i], 32'(8'h10 + i));
    check("t6_fifo_empty", f_empty, 1'b1);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
